// File: rtl/sram_pkg.sv
// Shared SRAM-port definitions: bus width defaults, pattern-engine colours and
// the arbiter state encodings.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W = 18;
   localparam int unsigned SRAM_DATA_W = 32;

   localparam logic [23:0] COLOR_BLACK = 24'h000000;
   localparam logic [23:0] COLOR_WHITE = 24'hFFFFFF;
   localparam logic [23:0] COLOR_RED   = 24'hFF0000;
   localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
   localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;
   localparam logic [23:0] COLOR_GREY  = 24'hC0C0C0;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ACCESS  = 2'd1;
   localparam logic [1:0] RECOVER = 2'd2;

   // Pixel colour packed into the low bits of one SRAM word.
   function automatic logic [SRAM_DATA_W-1:0] color_word(input logic [23:0] rgb);
      return {{(SRAM_DATA_W-24){1'b0}}, rgb};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting one past last_grant_i,
// wrapping around through the requester list.
module rr_pick
   import sram_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
)(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [2:0]         last_grant_i,
   output logic               any_o,
   output logic [2:0]         winner_o
);

   logic [NUM_REQ-1:0]   above;
   logic [2*NUM_REQ-1:0] dbl;
   int unsigned          pos;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
         above[i] = (i > 32'(last_grant_i));
      // Lower half keeps only requesters after last_grant; upper half is the wrap.
      dbl = {req_i, req_i & above};
      pos = 0;
      for (int unsigned i = 2*NUM_REQ; i > 0; i--)
         if (dbl[i-1]) pos = i - 1;
      any_o    = |req_i;
      winner_o = (pos >= NUM_REQ) ? 3'(pos - NUM_REQ) : 3'(pos);
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing the single SRAM port among NUM_REQ engines.
// Each grant runs IDLE -> ACCESS (strobe high) -> RECOVER (strobe low) -> IDLE.
module sram_port_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = SRAM_ADDR_W,
   parameter int unsigned DATA_W  = SRAM_DATA_W
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [NUM_REQ-1:0]        rdata_valid,
   output logic [ADDR_W-1:0]         sram_addr,
   output logic [DATA_W-1:0]         sram_wdata,
   output logic                      sram_wren,
   output logic                      sram_rden,
   input  logic [DATA_W-1:0]         sram_rdata,
   output logic                      busy,
   output logic [2:0]                grant_id
);

   logic [1:0]         state_q, state_d;
   logic [2:0]         last_grant_q, last_grant_d;
   logic [2:0]         grant_id_q, grant_id_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               wren_q, wren_d;
   logic               rden_q, rden_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
   logic               busy_q, busy_d;

   logic               pick_any;
   logic [2:0]         pick_id;
   logic [NUM_REQ-1:0] pick_oh, grant_oh;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .any_o        (pick_any),
      .winner_o     (pick_id)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pick_oh[i]  = (32'(pick_id) == i);
         grant_oh[i] = (32'(grant_id_q) == i);
         if (pick_oh[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Strobes and ack are loaded on the IDLE edge so the registered outputs
   // are high exactly during the ACCESS cycle.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wren_d       = 1'b0;
      rden_d       = 1'b0;
      ack_d        = '0;
      rdata_d      = rdata_q;
      rvalid_d     = '0;
      busy_d       = busy_q;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d    = ACCESS;
               grant_id_d = pick_id;
               we_d       = sel_we;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               wren_d     = sel_we;
               rden_d     = ~sel_we;
               ack_d      = pick_oh;
               busy_d     = 1'b1;
            end
         end
         ACCESS: begin
            state_d      = RECOVER;
            last_grant_d = grant_id_q;
         end
         RECOVER: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (!we_q) begin
               rdata_d  = sram_rdata;
               rvalid_d = grant_oh;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 3'(NUM_REQ - 1);
         grant_id_q   <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wren_q       <= 1'b0;
         rden_q       <= 1'b0;
         ack_q        <= '0;
         rdata_q      <= '0;
         rvalid_q     <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wren_q       <= wren_d;
         rden_q       <= rden_d;
         ack_q        <= ack_d;
         rdata_q      <= rdata_d;
         rvalid_q     <= rvalid_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ack     = ack_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign sram_addr   = addr_q;
   assign sram_wdata  = wdata_q;
   assign sram_wren   = wren_q;
   assign sram_rden   = rden_q;
   assign busy        = busy_q;
   assign grant_id    = grant_id_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter and sequencer for the single 18-bit-address, 32-bit-data SRAM port. It lets up to NUM_REQ engines share that one port: the colour-pattern generator, the camera capture path and the image-processing stages. Each engine issues single-word read or write requests. The arbiter grants one request at a time and drives the SRAM with the two-phase strobe (wren high for one cycle, then low) that the SRAM interface requires. Read data is routed back to the requester that issued the read.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 18, SRAM word address width
- DATA_W, 32, SRAM data width

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending; held until matching req_ack
- req_we  in  NUM_REQ  1 = write, 0 = read; valid with req_valid
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data; requester i at [i*DATA_W +: DATA_W]
- req_ack  out  NUM_REQ  one-cycle pulse; request accepted; requester drops or changes its request on the following edge
- rdata  out  DATA_W  read data, shared by all requesters
- rdata_valid  out  NUM_REQ  one-cycle pulse to the read's owner; rdata is valid in the same cycle
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_wren  out  1  SRAM write strobe
- sram_rden  out  1  SRAM read strobe
- sram_rdata  in  DATA_W  SRAM read data; valid the cycle after sram_rden is asserted
- busy  out  1  high while in ACCESS or RECOVER
- grant_id  out  3  index of the current or last granted requester

## Operation
- FSM states: IDLE, ACCESS, RECOVER. Every state is registered, and every output is a register.
- IDLE:
  - When any req_valid bit is set, pick the winner g with rr_pick, searching from last_grant+1 with wrap-around.
  - Latch addr, wdata and we of g, set grant_id = g, and go to ACCESS.
  - With no requests, stay in IDLE with both strobes low.
- ACCESS (1 cycle):
  - sram_addr and sram_wdata come from the latch.
  - sram_wren = we, sram_rden = ~we.
  - req_ack[g] = 1.
  - last_grant <= g.
  - Go to RECOVER.
- RECOVER (1 cycle):
  - sram_wren = 0 and sram_rden = 0; sram_addr is held.
  - On a read, register sram_rdata into rdata and pulse rdata_valid[g] in the next cycle (IDLE).
  - Go to IDLE.
- Fairness: a requester that stays valid is served at least once every NUM_REQ grants.
- Boundary conditions:
  - Simultaneous requests: the bit after last_grant wins. After reset, last_grant = NUM_REQ-1, so requester 0 has first priority.
  - A request that arrives during ACCESS or RECOVER waits for the next IDLE.
  - A req_valid that drops before its ack is legal; no access is issued for it.
  - A requester that does not drop req_valid after its ack is treated as a new request.
  - A requester index >= NUM_REQ never wins.
  - Reset mid-transaction returns the FSM to IDLE on the next edge. The write strobe is low from that edge on, and a pending rdata_valid is discarded.

## Timing
- Reset values:
  - state = IDLE, last_grant = NUM_REQ-1, grant_id = 0
  - sram_addr = 0, sram_wdata = 0, sram_wren = 0, sram_rden = 0
  - req_ack = 0, rdata = 0, rdata_valid = 0, busy = 0
- Latency:
  - req_valid sampled in IDLE at edge T: strobe and ack high in T+1, strobe low in T+2.
  - For a read, rdata_valid is high in T+3.
- Throughput: one access per 3 cycles under continuous load. Back-to-back grants go to different requesters whenever more than one is valid.
- sram_wren and sram_rden are never high together, and never high for two consecutive cycles.

## Structure
- Shared package sram_pkg:
  - ADDR_W and DATA_W defaults
  - the colour constants used by the pattern engines
  - arbiter state encodings: IDLE = 0, ACCESS = 1, RECOVER = 2
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: req vector and last_grant. Outputs: any, winner index.
  - Implemented with a double-width masked priority encode.
- The arbiter itself holds the FSM, the request latch and the output registers.

## Test plan
- Reset, then requester 1 writes addr 0x00010 data 0xC0C0C0 → sram_wren high exactly one cycle with those values, req_ack[1] in the same cycle, busy high 2 cycles.
- Requester 2 reads addr 0x3FFFF with the SRAM model returning 0xDEADBEEF → sram_rden high one cycle, rdata_valid[2] high with rdata = 0xDEADBEEF 2 cycles later, no rdata_valid on other bits.
- All 3 requesters held valid continuously → grant order 0,1,2,0,1,2, one strobe every 3 cycles, never two strobes active together.
- Requester 0 continuously valid while requester 2 requests once → requester 2 is granted within 2 grants.
- Requester 1 drops req_valid before its ack → no SRAM access, FSM stays IDLE.
- Reset asserted during the ACCESS of a write → next cycle sram_wren = 0 and all outputs at reset values; the next request is granted to requester 0 first.
